// File: rtl/pcie_pkg.sv
// Shared PCIe completion definitions: FSM states, completion header constants,
// request-header field extractors and the completion header builder.
package pcie_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WAIT_R = 3'd1,
    ST_HDR    = 3'd2,
    ST_DATA   = 3'd3,
    ST_DRAIN  = 3'd4
  } cpl_state_e;

  localparam logic [2:0] CPL_FMT_CPL  = 3'b000;
  localparam logic [2:0] CPL_FMT_CPLD = 3'b010;
  localparam logic [4:0] CPL_TYPE     = 5'b01010;
  localparam logic [2:0] CPL_STS_SC   = 3'b000;
  localparam logic [2:0] CPL_STS_CA   = 3'b100;

  function automatic logic [15:0] get_reqid_from_req_hdr(input logic [127:0] hdr);
    return hdr[63:48];
  endfunction

  function automatic logic [7:0] get_tag_from_req_hdr(input logic [127:0] hdr);
    return hdr[47:40];
  endfunction

  function automatic logic [9:0] get_len_dw_from_req_hdr(input logic [127:0] hdr);
    return hdr[9:0];
  endfunction

  // 4DW header: low address lives in DW3, bits [1:0] are reserved (DW aligned)
  function automatic logic [6:0] get_addr_from_req_hdr(input logic [127:0] hdr);
    return {hdr[102:98], 2'b00};
  endfunction

  function automatic logic [127:0] build_cpl_hdr(
    input logic [15:0] completer_id,
    input logic [15:0] reqid,
    input logic [7:0]  tag,
    input logic [9:0]  len_dw,
    input logic [6:0]  addr,
    input logic        abort
  );
    logic [31:0] dw0;
    logic [31:0] dw1;
    logic [31:0] dw2;
    dw0        = '0;
    dw0[31:29] = abort ? CPL_FMT_CPL : CPL_FMT_CPLD;
    dw0[28:24] = CPL_TYPE;
    dw0[9:0]   = abort ? 10'd0 : len_dw;
    // len_dw*4 in 12 bits wraps 1024 DW (len_dw = 0) to a byte count of 0
    dw1        = {completer_id, (abort ? CPL_STS_CA : CPL_STS_SC), 1'b0, len_dw, 2'b00};
    dw2        = {reqid, tag, 1'b0, addr};
    return {32'h0, dw2, dw1, dw0};
  endfunction

endpackage

// File: rtl/cpl_hdr_build.sv
// Combinational completion header assembly from captured request fields.
module cpl_hdr_build
  import pcie_pkg::*;
#(
  parameter logic [15:0] COMPLETER_ID = 16'h0100
) (
  input  logic [15:0]  reqid,
  input  logic [7:0]   tag,
  input  logic [9:0]   len_dw,
  input  logic [6:0]   addr,
  input  logic         abort,
  output logic [127:0] hdr
);

  always_comb begin
    hdr = build_cpl_hdr(COMPLETER_ID, reqid, tag, len_dw, addr, abort);
  end

endmodule

// File: rtl/cpld_gen.sv
// Memory-read completion generator: turns an AXI4 R burst into a PCIe
// completion header plus a pass-through payload stream.
module cpld_gen
  import pcie_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 256,
  parameter logic [15:0] COMPLETER_ID = 16'h0100
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_wren,
  input  logic [127:0]          req_hdr,
  output logic                  cpl_busy,
  input  logic                  rvalid,
  output logic                  rready,
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic [9:0]            rid,
  input  logic [1:0]            rresp,
  input  logic                  rlast,
  output logic                  cpl_hdr_valid,
  output logic [127:0]          cpl_hdr,
  input  logic                  cpl_hdr_ready,
  output logic                  cpl_data_valid,
  output logic [DATA_WIDTH-1:0] cpl_data,
  output logic                  cpl_data_last,
  input  logic                  cpl_data_ready,
  output logic                  err
);

  localparam int unsigned DW_PER_BEAT = DATA_WIDTH / 32;

  cpl_state_e   state_q, state_d;
  logic [15:0]  reqid_q, reqid_d;
  logic [7:0]   tag_q, tag_d;
  logic [9:0]   len_dw_q, len_dw_d;
  logic [6:0]   addr_q, addr_d;
  logic         first_err_q, first_err_d;
  logic [10:0]  beat_cnt_q, beat_cnt_d;
  logic         hdr_valid_q, hdr_valid_d;
  logic [127:0] hdr_q, hdr_d;
  logic         err_q, err_d;
  logic [127:0] hdr_built;
  logic [10:0]  len_eff;
  logic [10:0]  exp_beats;
  logic         beat_acc;
  logic         unused_ok;

  assign unused_ok = ^{rid[9:8], req_hdr};

  cpl_hdr_build #(
    .COMPLETER_ID(COMPLETER_ID)
  ) u_hdr_build (
    .reqid (reqid_q),
    .tag   (tag_q),
    .len_dw(len_dw_q),
    .addr  (addr_q),
    .abort (rresp != 2'b00),
    .hdr   (hdr_built)
  );

  always_comb begin
    len_eff   = (len_dw_q == '0) ? 11'd1024 : {1'b0, len_dw_q};
    exp_beats = 11'((32'(len_eff) + DW_PER_BEAT - 1) / DW_PER_BEAT);
  end

  assign cpl_busy      = (state_q != ST_IDLE);
  assign cpl_hdr_valid = hdr_valid_q;
  assign cpl_hdr       = hdr_q;
  assign err           = err_q;

  always_comb begin
    state_d        = state_q;
    reqid_d        = reqid_q;
    tag_d          = tag_q;
    len_dw_d       = len_dw_q;
    addr_d         = addr_q;
    first_err_d    = first_err_q;
    beat_cnt_d     = beat_cnt_q;
    hdr_valid_d    = hdr_valid_q;
    hdr_d          = hdr_q;
    err_d          = 1'b0;
    rready         = 1'b0;
    cpl_data_valid = 1'b0;
    cpl_data       = '0;
    cpl_data_last  = 1'b0;
    beat_acc       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req_wren) begin
          reqid_d     = get_reqid_from_req_hdr(req_hdr);
          tag_d       = get_tag_from_req_hdr(req_hdr);
          len_dw_d    = get_len_dw_from_req_hdr(req_hdr);
          addr_d      = get_addr_from_req_hdr(req_hdr);
          first_err_d = 1'b0;
          beat_cnt_d  = '0;
          state_d     = ST_WAIT_R;
        end
      end
      ST_WAIT_R: begin
        // First beat is only peeked here; it is accepted later in DATA/DRAIN
        if (rvalid) begin
          first_err_d = (rresp != 2'b00);
          hdr_d       = hdr_built;
          hdr_valid_d = 1'b1;
          state_d     = ST_HDR;
        end
      end
      ST_HDR: begin
        if (cpl_hdr_ready) begin
          hdr_valid_d = 1'b0;
          state_d     = first_err_q ? ST_DRAIN : ST_DATA;
        end
      end
      ST_DATA: begin
        rready         = cpl_data_ready;
        cpl_data_valid = rvalid;
        cpl_data       = rdata;
        cpl_data_last  = rlast;
        beat_acc       = rvalid && cpl_data_ready;
      end
      ST_DRAIN: begin
        rready   = 1'b1;
        beat_acc = rvalid;
      end
      default: state_d = ST_IDLE;
    endcase

    if (beat_acc) begin
      beat_cnt_d = beat_cnt_q + 11'd1;
      if (rlast && (beat_cnt_q != exp_beats - 11'd1)) err_d = 1'b1;
      if (rid[7:0] != tag_q) err_d = 1'b1;
      if ((state_q == ST_DATA) && (beat_cnt_q != '0) && (rresp != 2'b00)) err_d = 1'b1;
      if (rlast) state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      reqid_q     <= '0;
      tag_q       <= '0;
      len_dw_q    <= '0;
      addr_q      <= '0;
      first_err_q <= 1'b0;
      beat_cnt_q  <= '0;
      hdr_valid_q <= 1'b0;
      hdr_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      reqid_q     <= reqid_d;
      tag_q       <= tag_d;
      len_dw_q    <= len_dw_d;
      addr_q      <= addr_d;
      first_err_q <= first_err_d;
      beat_cnt_q  <= beat_cnt_d;
      hdr_valid_q <= hdr_valid_d;
      hdr_q       <= hdr_d;
      err_q       <= err_d;
    end
  end

endmodule
